// File: rtl/uart_pkg.sv
// Shared UART definitions: 50 MHz baud divisors, baud select decode, byte FSM states.
package uart_pkg;

   localparam int unsigned BPS_W = 13;

   localparam logic [BPS_W-1:0] BPS_9600   = 13'd5208;
   localparam logic [BPS_W-1:0] BPS_19200  = 13'd2604;
   localparam logic [BPS_W-1:0] BPS_38400  = 13'd1302;
   localparam logic [BPS_W-1:0] BPS_57600  = 13'd868;
   localparam logic [BPS_W-1:0] BPS_115200 = 13'd434;

   // Idle bit-times after an accepted byte before a partial word is dropped
   localparam int unsigned TIMEOUT_BITS = 20;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

   // baud_set -> clock cycles per bit; codes above 4 alias the fastest rate
   function automatic logic [BPS_W-1:0] bps_of(input logic [2:0] baud_set);
      logic [BPS_W-1:0] bps;
      case (baud_set)
         3'd0:    bps = BPS_9600;
         3'd1:    bps = BPS_19200;
         3'd2:    bps = BPS_38400;
         3'd3:    bps = BPS_57600;
         default: bps = BPS_115200;
      endcase
      return bps;
   endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// Single 8N1 byte receiver: input synchronizer, bit timer and byte FSM.
module uart_byte_rx
   import uart_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       uart_rx,
   input  logic [2:0] baud_set,
   output logic [7:0] byte_data,
   output logic       byte_done,
   output logic       byte_err,
   output logic       rx_busy
);

   logic             rx_s1, rx_s2, rx_d;
   logic             fall_c, tick_c;
   rx_state_t        state, state_nxt;
   logic [BPS_W-1:0] bps_q, cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shift;

   // Two-flop synchronizer plus edge register, all idling high
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
         rx_d  <= 1'b1;
      end else begin
         rx_s1 <= uart_rx;
         rx_s2 <= rx_s1;
         rx_d  <= rx_s2;
      end
   end

   assign fall_c = rx_d & ~rx_s2;

   // Sample point: half a bit into the start bit, then one full bit apart
   always_comb begin
      tick_c = 1'b0;
      if (state == RX_START)
         tick_c = (cnt == (bps_q >> 1) - BPS_W'(1));
      else if (state != RX_IDLE)
         tick_c = (cnt == bps_q - BPS_W'(1));
   end

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= RX_IDLE;
      else          state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         RX_IDLE:  if (fall_c) state_nxt = RX_START;
         RX_START: if (tick_c) state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
         RX_DATA:  if (tick_c && bit_idx == 3'd7) state_nxt = RX_STOP;
         RX_STOP:  if (tick_c) state_nxt = RX_IDLE;
         default:  state_nxt = RX_IDLE;
      endcase
   end

   // Bit timer, shift register and registered byte outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bps_q     <= BPS_115200;
         cnt       <= '0;
         bit_idx   <= '0;
         shift     <= '0;
         byte_data <= '0;
         byte_done <= 1'b0;
         byte_err  <= 1'b0;
         rx_busy   <= 1'b0;
      end else begin
         byte_done <= 1'b0;
         byte_err  <= 1'b0;
         if (state == RX_IDLE) begin
            cnt     <= '0;
            bit_idx <= '0;
            if (fall_c) bps_q <= bps_of(baud_set);
         end else if (tick_c) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + BPS_W'(1);
         end
         if (state == RX_START && tick_c && !rx_s2) rx_busy <= 1'b1;
         if (state == RX_DATA && tick_c) begin
            shift   <= {rx_s2, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
         end
         if (state == RX_STOP && tick_c) begin
            rx_busy <= 1'b0;
            if (rx_s2) begin
               byte_done <= 1'b1;
               byte_data <= shift;
            end else begin
               byte_err  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/uart_data_rx.sv
// Multi-byte UART receiver: assembles DATA_WIDTH/8 bytes into one word.
// Optional feature: define UART_DATA_RX_TIMEOUT_EN to drop stalled partial words.
module uart_data_rx
   import uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter bit          MSB_FIRST  = 1'b0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  uart_rx,
   input  logic [2:0]            baud_set,
   output logic [DATA_WIDTH-1:0] data,
   output logic                  rx_done,
   output logic                  frame_err,
   output logic                  uart_state
);

   localparam int unsigned NBYTES = DATA_WIDTH / 8;
   localparam int unsigned CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NBYTES - 1);

   logic [7:0]            byte_data;
   logic                  byte_done, byte_err, rx_busy;
   logic [CNT_W-1:0]      byte_cnt, slot_c;
   logic [DATA_WIDTH-1:0] asm_q, asm_next_c;
   logic                  timeout_c;

   uart_byte_rx u_byte_rx (
      .clk       (clk),
      .reset_n   (reset_n),
      .uart_rx   (uart_rx),
      .baud_set  (baud_set),
      .byte_data (byte_data),
      .byte_done (byte_done),
      .byte_err  (byte_err),
      .rx_busy   (rx_busy)
   );

   // Place the incoming byte into its slot of the assembly word
   always_comb begin
      slot_c     = MSB_FIRST ? (LAST - byte_cnt) : byte_cnt;
      asm_next_c = asm_q;
      for (int i = 0; i < NBYTES; i++)
         if (slot_c == CNT_W'(i)) asm_next_c[i*8 +: 8] = byte_data;
   end

`ifdef UART_DATA_RX_TIMEOUT_EN
   localparam int unsigned TO_W = 17;

   logic [TO_W-1:0] idle_cnt;
   logic [TO_W-1:0] idle_lim_c;

   assign idle_lim_c = TO_W'(TIMEOUT_BITS * bps_of(baud_set)) - TO_W'(1);
   assign timeout_c  = (byte_cnt != '0) && !rx_busy && (idle_cnt == idle_lim_c);

   // Idle time since the last accepted byte of an unfinished word
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         idle_cnt <= '0;
      else if (byte_cnt == '0 || rx_busy || byte_done || timeout_c)
         idle_cnt <= '0;
      else
         idle_cnt <= idle_cnt + TO_W'(1);
   end
`else
   assign timeout_c = 1'b0;
`endif

   // Word assembly, byte counter, completion/error pulses and busy flag
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data       <= '0;
         rx_done    <= 1'b0;
         frame_err  <= 1'b0;
         uart_state <= 1'b0;
         byte_cnt   <= '0;
         asm_q      <= '0;
      end else begin
         rx_done   <= 1'b0;
         frame_err <= 1'b0;
         if (byte_err || timeout_c) begin
            frame_err  <= 1'b1;
            byte_cnt   <= '0;
            asm_q      <= '0;
            uart_state <= 1'b0;
         end else if (byte_done) begin
            if (byte_cnt == LAST) begin
               data       <= asm_next_c;
               rx_done    <= 1'b1;
               byte_cnt   <= '0;
               asm_q      <= '0;
               uart_state <= 1'b0;
            end else begin
               asm_q    <= asm_next_c;
               byte_cnt <= byte_cnt + CNT_W'(1);
            end
         end else if (rx_busy) begin
            uart_state <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_data_rx.sv
// Self-checking bench for uart_data_rx: LSB-first and MSB-first instances on one line.
`timescale 1ns/1ps
module tb_uart_data_rx;

   localparam int unsigned BIT = 434;
   localparam int unsigned DW  = 32;

`ifdef UART_DATA_RX_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          uart_rx = 1'b1;
   logic [2:0]    baud_set = 3'd4;
   logic [DW-1:0] data_l, data_m;
   logic          done_l, done_m, ferr_l, ferr_m, st_l, st_m;

   int checks = 0;
   int failures = 0;
   int n_done_l = 0, n_done_m = 0, n_ferr_l = 0, n_ferr_m = 0, n_st = 0, n_both = 0;
   logic [DW-1:0] cap_l = '0, cap_m = '0;

   always #10 clk = ~clk;

   uart_data_rx #(.DATA_WIDTH(DW), .MSB_FIRST(0)) dut_l (
      .clk(clk), .reset_n(reset_n), .uart_rx(uart_rx), .baud_set(baud_set),
      .data(data_l), .rx_done(done_l), .frame_err(ferr_l), .uart_state(st_l));

   uart_data_rx #(.DATA_WIDTH(DW), .MSB_FIRST(1)) dut_m (
      .clk(clk), .reset_n(reset_n), .uart_rx(uart_rx), .baud_set(baud_set),
      .data(data_m), .rx_done(done_m), .frame_err(ferr_m), .uart_state(st_m));

   // Pulse counters and word capture, sampled on the inactive edge
   always @(negedge clk) begin
      if (done_l) begin n_done_l++; cap_l = data_l; end
      if (done_m) begin n_done_m++; cap_m = data_m; end
      if (ferr_l) n_ferr_l++;
      if (ferr_m) n_ferr_m++;
      if (st_l)   n_st++;
      if ((done_l && ferr_l) || (done_m && ferr_m)) n_both++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference word: first byte is least significant (or most, if msb)
   function automatic logic [31:0] model(input logic [7:0] b[4], input bit msb);
      longint unsigned w = 0;
      for (int i = 0; i < 4; i++)
         w = msb ? (w * 256 + longint'(b[i])) : (w + longint'(b[i]) * (64'd1 << (8 * i)));
      return 32'(w);
   endfunction

   // One 8N1 frame; baud_set is scrambled mid-byte to show it is latched
   task automatic send_byte(input logic [7:0] b, input bit stop_ok);
      logic [2:0] keep;
      keep = baud_set;
      uart_rx = 1'b0;
      repeat (BIT) @(negedge clk);
      baud_set = 3'($urandom_range(0, 7));
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (BIT) @(negedge clk);
      end
      baud_set = keep;
      uart_rx = stop_ok;
      repeat (BIT) @(negedge clk);
      uart_rx = 1'b1;
   endtask

   task automatic send_word(input logic [7:0] b[4]);
      baud_set = 3'($urandom_range(4, 7));
      for (int i = 0; i < 4; i++) begin
         send_byte(b[i], 1'b1);
         repeat ($urandom_range(0, 30)) @(negedge clk);
      end
      repeat (5) @(negedge clk);
   endtask

   initial begin
      logic [7:0] w[4];
      logic [7:0] r0, r1;
      int bd, bf, bs;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_data_l", data_l, 32'h0);
      chk("rst_data_m", data_m, 32'h0);
      chk("rst_done", {31'd0, done_l}, 32'd0);
      chk("rst_ferr", {31'd0, ferr_l}, 32'd0);
      chk("rst_state", {31'd0, st_l}, 32'd0);
      reset_n = 1'b1;
      repeat (10) @(negedge clk);

      // Start glitch shorter than half a bit
      bd = n_done_l; bf = n_ferr_l; bs = n_st;
      uart_rx = 1'b0;
      repeat (100) @(negedge clk);
      uart_rx = 1'b1;
      repeat (2 * BIT) @(negedge clk);
      chk("glitch_state", 32'(n_st - bs), 32'd0);
      chk("glitch_done", 32'(n_done_l - bd), 32'd0);
      chk("glitch_ferr", 32'(n_ferr_l - bf), 32'd0);

      // Nominal word, uart_state held across the inter-byte gap
      w = '{8'h67, 8'h45, 8'h23, 8'h01};
      bd = n_done_l; bf = n_ferr_l;
      baud_set = 3'd4;
      send_byte(w[0], 1'b1);
      repeat (3) @(negedge clk);
      chk("nom_state_mid", {31'd0, st_l}, 32'd1);
      for (int i = 1; i < 4; i++) send_byte(w[i], 1'b1);
      repeat (5) @(negedge clk);
      chk("nom_done_cnt", 32'(n_done_l - bd), 32'd1);
      chk("nom_done_m", 32'(n_done_m - bd), 32'd1);
      chk("nom_data_l", cap_l, model(w, 1'b0));
      chk("nom_data_m", cap_m, model(w, 1'b1));
      chk("nom_state_end", {31'd0, st_l}, 32'd0);
      chk("nom_ferr", 32'(n_ferr_l - bf), 32'd0);
      repeat (200) @(negedge clk);
      chk("nom_hold", data_l, 32'h01234567);

      // Framing error on the second byte, then a clean word
      r0 = 8'($urandom);
      r1 = 8'($urandom);
      bd = n_done_l; bf = n_ferr_l;
      send_byte(r0, 1'b1);
      send_byte(r1, 1'b0);
      repeat (20 + $urandom_range(0, 30)) @(negedge clk);
      chk("ferr_cnt", 32'(n_ferr_l - bf), 32'd1);
      chk("ferr_cnt_m", 32'(n_ferr_m - bf), 32'd1);
      chk("ferr_no_done", 32'(n_done_l - bd), 32'd0);
      chk("ferr_state", {31'd0, st_l}, 32'd0);
      chk("ferr_hold", data_l, 32'h01234567);
      w = '{8'hFF, 8'h00, 8'h00, 8'h00};
      send_word(w);
      chk("ferr_next_done", 32'(n_done_l - bd), 32'd1);
      chk("ferr_next_l", cap_l, model(w, 1'b0));
      chk("ferr_next_m", cap_m, model(w, 1'b1));

      // Two bytes then idle: timeout window, then reset mid-word
      r0 = 8'($urandom);
      r1 = 8'($urandom);
      bd = n_done_l; bf = n_ferr_l;
      baud_set = 3'($urandom_range(4, 7));
      send_byte(r0, 1'b1);
      send_byte(r1, 1'b1);
      repeat (2) @(negedge clk);
      chk("part_state", {31'd0, st_l}, 32'd1);
      repeat (TIMEOUT_CYC()) @(negedge clk);
      chk("to_ferr", 32'(n_ferr_l - bf), TO_EN ? 32'd1 : 32'd0);
      chk("to_state", {31'd0, st_l}, TO_EN ? 32'd0 : 32'd1);
      chk("to_no_done", 32'(n_done_l - bd), 32'd0);
      reset_n = 1'b0;
      #1;
      chk("mrst_data_l", data_l, 32'h0);
      chk("mrst_data_m", data_m, 32'h0);
      chk("mrst_state", {31'd0, st_l}, 32'd0);
      chk("mrst_done", {31'd0, done_l}, 32'd0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("mrst_no_done", 32'(n_done_l - bd), 32'd0);
      w = '{8'h5A, 8'h5A, 8'hA5, 8'hA5};
      send_word(w);
      chk("mrst_next_done", 32'(n_done_l - bd), 32'd1);
      chk("mrst_next_l", cap_l, model(w, 1'b0));
      chk("mrst_next_m", cap_m, model(w, 1'b1));
      chk("mrst_next_val", cap_l, 32'hA5A55A5A);

      chk("done_ferr_excl", 32'(n_both), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   function automatic int TIMEOUT_CYC();
      return 20 * BIT + 300;
   endfunction

endmodule
